// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller sitting downstream of the level blocks.
// Picks the active level, holds it in reset during pauses, times the death and
// level-clear pauses in frame ticks, and counts attempts on the current level.
// Optional build macro: LVSEQ_PRACTICE_EN adds a 'practice' input that makes
// deaths free (no attempt increment) and shortens the death pause to one tick.
module level_sequencer #(
  parameter int NUM_LV  = 4,
  parameter int LW      = 2,
  parameter int HOLD_FR = 60,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imgReturn,
  input  logic          start,
  input  logic          LVcp,
  input  logic          hit,
`ifdef LVSEQ_PRACTICE_EN
  input  logic          practice,
`endif
  output logic [LW-1:0] lvSel,
  output logic          lvHold,
  output logic          dead,
  output logic          won,
  output logic [AW-1:0] attempts
);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    DEAD,
    CLEAR,
    WIN
  } state_t;

  localparam logic [7:0]    LAST_FR = 8'(HOLD_FR - 1);
  localparam logic [LW-1:0] LAST_LV = LW'(NUM_LV - 1);
  localparam logic [AW-1:0] ONE_ATT = AW'(1);

  state_t        state;
  state_t        state_nx;
  logic [7:0]    frame_cnt;
  logic [7:0]    frame_cnt_nx;
  logic [LW-1:0] lv_nx;
  logic [AW-1:0] att_nx;
  logic [AW-1:0] att_inc;
  logic          practice_death;
  logic          practice_death_nx;
  logic          practice_on;

`ifdef LVSEQ_PRACTICE_EN
  assign practice_on = practice;
`else
  assign practice_on = 1'b0;
`endif

  // Next-state, pause timing and level/attempt bookkeeping
  always_comb begin
    state_nx          = state;
    frame_cnt_nx      = frame_cnt;
    lv_nx             = lvSel;
    att_nx            = attempts;
    practice_death_nx = practice_death;
    att_inc           = (attempts == '1) ? attempts : attempts + ONE_ATT;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = PLAY;
          lv_nx    = '0;
          att_nx   = ONE_ATT;
        end
      end
      PLAY: begin
        if (hit) begin
          state_nx          = DEAD;
          frame_cnt_nx      = '0;
          practice_death_nx = practice_on;
        end else if (LVcp) begin
          state_nx     = CLEAR;
          frame_cnt_nx = '0;
        end
      end
      DEAD: begin
        if (start || (imgReturn && (practice_death || frame_cnt == LAST_FR))) begin
          state_nx     = PLAY;
          frame_cnt_nx = '0;
          if (!practice_death) begin
            att_nx = att_inc;
          end
        end else if (imgReturn) begin
          frame_cnt_nx = frame_cnt + 8'd1;
        end
      end
      CLEAR: begin
        if (imgReturn) begin
          if (frame_cnt == LAST_FR) begin
            frame_cnt_nx = '0;
            if (lvSel == LAST_LV) begin
              state_nx = WIN;
            end else begin
              state_nx = PLAY;
              lv_nx    = lvSel + LW'(1);
              att_nx   = ONE_ATT;
            end
          end else begin
            frame_cnt_nx = frame_cnt + 8'd1;
          end
        end
      end
      WIN: begin
        if (start) begin
          state_nx = IDLE;
          lv_nx    = '0;
          att_nx   = ONE_ATT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs; lvHold is high in every state except PLAY
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      lvSel          <= '0;
      attempts       <= ONE_ATT;
      practice_death <= 1'b0;
      lvHold         <= 1'b1;
      dead           <= 1'b0;
      won            <= 1'b0;
    end else begin
      state          <= state_nx;
      frame_cnt      <= frame_cnt_nx;
      lvSel          <= lv_nx;
      attempts       <= att_nx;
      practice_death <= practice_death_nx;
      lvHold         <= (state_nx != PLAY);
      dead           <= (state_nx == DEAD);
      won            <= (state_nx == WIN);
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed game-flow scenarios followed by random play,
// every cycle compared against a behavioural model of the game rules.
module tb_level_sequencer;

  localparam int NUM_LV = 4;
  localparam int LW     = 2;
  localparam int HOLD   = 60;
  localparam int AW     = 8;
  localparam int ATT_MAX = (1 << AW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DEAD  = 2;
  localparam int M_CLEAR = 3;
  localparam int M_WIN   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imgReturn;
  logic          start;
  logic          LVcp;
  logic          hit;
  logic          practice;
  logic [LW-1:0] lvSel;
  logic          lvHold;
  logic          dead;
  logic          won;
  logic [AW-1:0] attempts;

  int checks   = 0;
  int failures = 0;

  int m_mode;
  int m_lv;
  int m_att;
  int m_left;
  bit m_pd;

  // Free-running clock
  always #5 clk = ~clk;

  level_sequencer #(
    .NUM_LV (NUM_LV),
    .LW     (LW),
    .HOLD_FR(HOLD),
    .AW     (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .imgReturn(imgReturn),
    .start    (start),
    .LVcp     (LVcp),
    .hit      (hit),
`ifdef LVSEQ_PRACTICE_EN
    .practice (practice),
`endif
    .lvSel    (lvSel),
    .lvHold   (lvHold),
    .dead     (dead),
    .won      (won),
    .attempts (attempts)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of the game rules: pauses are counted down in frame ticks
  task automatic modelStep(input bit r, input bit s, input bit img, input bit cp, input bit h, input bit pr);
    if (r) begin
      m_mode = M_IDLE; m_lv = 0; m_att = 1; m_left = 0; m_pd = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_PLAY; m_lv = 0; m_att = 1; end
      M_PLAY: begin
        if (h) begin
          m_mode = M_DEAD; m_pd = pr; m_left = pr ? 1 : HOLD;
        end else if (cp) begin
          m_mode = M_CLEAR; m_left = HOLD;
        end
      end
      M_DEAD: begin
        if (s || (img && m_left == 1)) begin
          m_mode = M_PLAY;
          if (!m_pd && m_att < ATT_MAX) m_att++;
        end else if (img) begin
          m_left--;
        end
      end
      M_CLEAR: begin
        if (img) begin
          if (m_left == 1) begin
            if (m_lv == NUM_LV - 1) m_mode = M_WIN;
            else begin m_mode = M_PLAY; m_lv++; m_att = 1; end
          end else begin
            m_left--;
          end
        end
      end
      M_WIN: if (s) begin m_mode = M_IDLE; m_lv = 0; m_att = 1; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit img, input bit cp, input bit h);
    rst = r; start = s; imgReturn = img; LVcp = cp; hit = h;
    @(posedge clk);
    modelStep(r, s, img, cp, h, practice);
    #1;
    checkOutput("lvSel", 32'(lvSel), 32'(m_lv));
    checkOutput("attempts", 32'(attempts), 32'(m_att));
    checkOutput("lvHold", 32'(lvHold), 32'(m_mode != M_PLAY));
    checkOutput("dead", 32'(dead), 32'(m_mode == M_DEAD));
    checkOutput("won", 32'(won), 32'(m_mode == M_WIN));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0);
  endtask

  initial begin
    practice = 1'b0;
    m_mode = M_IDLE; m_lv = 0; m_att = 1; m_left = 0; m_pd = 0;

    // Reset and idle
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idleHold", 32'(lvHold), 32'd1);

    // Death pause lasts exactly HOLD ticks
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("playHold", 32'(lvHold), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    ticks(HOLD - 1);
    checkOutput("deadHeld", 32'(dead), 32'd1);
    ticks(1);
    checkOutput("deadDone", 32'(dead), 32'd0);
    checkOutput("att2", 32'(attempts), 32'd2);

    // Clear every level through to WIN, then back to IDLE
    for (int l = 0; l < NUM_LV; l++) begin
      applyStimulus(0, 0, 0, 1, 0);
      ticks(HOLD);
    end
    checkOutput("wonSet", 32'(won), 32'd1);
    checkOutput("winLv", 32'(lvSel), 32'(NUM_LV - 1));
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("idleLv", 32'(lvSel), 32'd0);
    checkOutput("idleAtt", 32'(attempts), 32'd1);

    // hit beats LVcp; start skips the death pause
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("hitWins", 32'(dead), 32'd1);
    checkOutput("hitLv", 32'(lvSel), 32'd0);
    ticks(10);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("skipPlay", 32'(lvHold), 32'd0);
    checkOutput("skipAtt", 32'(attempts), 32'd2);

    // Attempts saturate instead of wrapping
    for (int i = 0; i < ATT_MAX + 45; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0);
    end
    checkOutput("attSat", 32'(attempts), 32'(ATT_MAX));

    // Reset in the middle of a clear pause
    applyStimulus(0, 0, 0, 1, 0);
    ticks(30);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rstLv", 32'(lvSel), 32'd0);
    checkOutput("rstHold", 32'(lvHold), 32'd1);
    checkOutput("rstAtt", 32'(attempts), 32'd1);

`ifdef LVSEQ_PRACTICE_EN
    // Practice deaths are one tick long and free
    applyStimulus(0, 1, 0, 0, 0);
    practice = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    ticks(1);
    checkOutput("practiceExit", 32'(dead), 32'd0);
    checkOutput("practiceAtt", 32'(attempts), 32'd1);
    practice = 1'b0;
`endif

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
`ifdef LVSEQ_PRACTICE_EN
      practice = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
